// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with a two-entry skid buffer.
// The head entry drives the exec_* outputs, and the skid entry absorbs one extra
// instruction after EX stalls. in_ready depends only on registered state, so there
// is no combinational ready path from EX back to ID. Invalid entries always hold
// zeros, so hazard logic never sees a stale destination register.
//
//   state | meaning
//   EMPTY | no entries held, exec_* read zero
//   ONE   | head valid, skid empty
//   FULL  | head and skid valid, in_ready low
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] exec_data_1,
    output logic [DATA_W-1:0] exec_data_2,
    output logic [RD_W-1:0]   exec_rd,
    output logic [CTRL_W-1:0] exec_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    state_t state, state_nxt;
    entry_t head, head_nxt;
    entry_t skid, skid_nxt;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    assign in_entry  = {in_data1, in_data2, in_rd, in_ctrl};
    assign in_ready  = (state != FULL) && reset;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign exec_data_1 = head.data1;
    assign exec_data_2 = head.data2;
    assign exec_rd     = head.rd;
    assign exec_ctrl   = head.ctrl;

    // Occupancy decoded from the registered state.
    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next state and entry contents; flush clears everything and drops any same-cycle accept.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        if (flush) begin
            state_nxt = EMPTY;
            head_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_nxt  = in_entry;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_nxt = in_entry;
                    end else if (accept) begin
                        skid_nxt  = in_entry;
                        state_nxt = FULL;
                    end else if (pop) begin
                        head_nxt  = '0;
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_nxt  = skid;
                        skid_nxt  = '0;
                        state_nxt = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    head_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

    // State and storage registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            skid  <= skid_nxt;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus a randomized run
// compared against a queue-based reference model of a two-deep in-order buffer.
module tb_id_ex_pipe_reg;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data1 = '0;
    logic [31:0] in_data2 = '0;
    logic [4:0]  in_rd = '0;
    logic [7:0]  in_ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] exec_data_1;
    logic [31:0] exec_data_2;
    logic [4:0]  exec_rd;
    logic [7:0]  exec_ctrl;
    logic [1:0]  occupancy;

    logic        w_flush = 1'b0;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [63:0] w_in_data1 = '0;
    logic [63:0] w_in_data2 = '0;
    logic [5:0]  w_in_rd = '0;
    logic [15:0] w_in_ctrl = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic [63:0] w_exec_data_1;
    logic [63:0] w_exec_data_2;
    logic [5:0]  w_exec_rd;
    logic [15:0] w_exec_ctrl;
    logic [1:0]  w_occupancy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ent_t;

    ent_t mq[$];

    always #5 clock = ~clock;

    id_ex_pipe_reg dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data1(in_data1), .in_data2(in_data2), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .exec_data_1(exec_data_1), .exec_data_2(exec_data_2),
        .exec_rd(exec_rd), .exec_ctrl(exec_ctrl), .occupancy(occupancy)
    );

    id_ex_pipe_reg #(.DATA_W(64), .RD_W(6), .CTRL_W(16)) dut_wide (
        .clock(clock), .reset(reset), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data1(w_in_data1), .in_data2(w_in_data2), .in_rd(w_in_rd), .in_ctrl(w_in_ctrl),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .exec_data_1(w_exec_data_1), .exec_data_2(w_exec_data_2),
        .exec_rd(w_exec_rd), .exec_ctrl(w_exec_ctrl), .occupancy(w_occupancy)
    );

    // One clock edge: the model applies the handshake seen at the edge, then sampling at negedge.
    task automatic tick();
        bit acc, pp;
        ent_t e;
        @(posedge clock);
        acc = reset && in_valid && (mq.size() < 2);
        pp  = out_ready && (mq.size() > 0);
        if (!reset || flush) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                e.d1 = in_data1; e.d2 = in_data2; e.rd = in_rd; e.ctrl = in_ctrl;
                mq.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    task automatic drive(input bit v, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [7:0] ctrl);
        in_valid = v; in_data1 = d1; in_data2 = d2; in_rd = rd; in_ctrl = ctrl;
    endtask

    task automatic test_reset();
        reset = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 32'h1, 5'd7, 8'h55);
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (exec_data_1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1 got=%h exp=0", exec_data_1); end
        n_checks++; if ({exec_data_2, exec_rd, exec_ctrl} !== '0) begin n_fail++; $display("FAIL reset_exec got=%h exp=0", {exec_data_2, exec_rd, exec_ctrl}); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        drive(1'b0, '0, '0, '0, '0);
        reset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        drive(1'b1, 32'd1, 32'd2, 5'd3, 8'h11);
        tick();
        n_checks++; if ({exec_data_1, exec_data_2, exec_rd, exec_ctrl} !== {32'd1, 32'd2, 5'd3, 8'h11})
            begin n_fail++; $display("FAIL stream_A got=%h/%h/%h/%h exp=1/2/3/11", exec_data_1, exec_data_2, exec_rd, exec_ctrl); end
        n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_A_occ got=%0d/%b exp=1/1", occupancy, in_ready); end
        drive(1'b1, 32'd4, 32'd5, 5'd6, 8'h22);
        tick();
        n_checks++; if ({exec_data_1, exec_data_2, exec_rd, exec_ctrl} !== {32'd4, 32'd5, 5'd6, 8'h22})
            begin n_fail++; $display("FAIL stream_B got=%h/%h/%h/%h exp=4/5/6/22", exec_data_1, exec_data_2, exec_rd, exec_ctrl); end
        n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_B_occ got=%0d/%b exp=1/1", occupancy, in_ready); end
        drive(1'b0, '0, '0, '0, '0);
        tick();
        n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || exec_rd !== 5'd0)
            begin n_fail++; $display("FAIL stream_drain got=%0d/%b/%0d exp=0/0/0", occupancy, out_valid, exec_rd); end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 5'd3, 8'h11);
        tick();
        drive(1'b1, 32'd4, 32'd5, 5'd6, 8'h22);
        tick();
        n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || exec_rd !== 5'd3)
            begin n_fail++; $display("FAIL skid_full got=%0d/%b/%0d exp=2/0/3", occupancy, in_ready, exec_rd); end
        drive(1'b1, 32'd7, 32'd8, 5'd9, 8'h33);
        tick();
        n_checks++; if (occupancy !== 2'd2 || exec_rd !== 5'd3 || exec_data_1 !== 32'd1)
            begin n_fail++; $display("FAIL skid_hold got=%0d/%0d/%h exp=2/3/1", occupancy, exec_rd, exec_data_1); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (exec_rd !== 5'd6 || exec_ctrl !== 8'h22 || occupancy !== 2'd1 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL skid_B got=%0d/%h/%0d/%b exp=6/22/1/1", exec_rd, exec_ctrl, occupancy, in_ready); end
        tick();
        n_checks++; if (exec_rd !== 5'd9 || exec_data_2 !== 32'd8 || occupancy !== 2'd1)
            begin n_fail++; $display("FAIL skid_C got=%0d/%h/%0d exp=9/8/1", exec_rd, exec_data_2, occupancy); end
        drive(1'b0, '0, '0, '0, '0);
        tick();
        n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_drain got=%0d/%b exp=0/0", occupancy, out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 5'd3, 8'h11); tick();
        drive(1'b1, 32'd4, 32'd5, 5'd6, 8'h22); tick();
        drive(1'b1, 32'd7, 32'd8, 5'd9, 8'h33);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || exec_rd !== 5'd0 || exec_data_1 !== 32'd0)
            begin n_fail++; $display("FAIL flush_clear got=%0d/%b/%0d/%h exp=0/0/0/0", occupancy, out_valid, exec_rd, exec_data_1); end
        drive(1'b0, '0, '0, '0, '0);
        tick();
        n_checks++; if (occupancy !== 2'd0 || exec_rd !== 5'd0) begin n_fail++; $display("FAIL flush_no_C got=%0d/%0d exp=0/0", occupancy, exec_rd); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 5'd3, 8'h11); tick();
        drive(1'b1, 32'd4, 32'd5, 5'd6, 8'h22); tick();
        drive(1'b0, '0, '0, '0, '0);
        reset = 1'b0;
        tick();
        n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || {exec_data_1, exec_data_2, exec_rd, exec_ctrl} !== '0)
            begin n_fail++; $display("FAIL rstmid_clear got=%0d/%b/%b/%0d exp=0/0/0/0", occupancy, out_valid, in_ready, exec_rd); end
        reset = 1'b1;
        drive(1'b1, 32'hCAFE, 32'hF00D, 5'd31, 8'hFF);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        n_checks++; if (occupancy !== 2'd1 || exec_rd !== 5'd31 || exec_ctrl !== 8'hFF || exec_data_1 !== 32'hCAFE)
            begin n_fail++; $display("FAIL rstmid_D got=%0d/%0d/%h/%h exp=1/31/ff/cafe", occupancy, exec_rd, exec_ctrl, exec_data_1); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_alone got=%0d/%b exp=0/0", occupancy, out_valid); end
    endtask

    task automatic test_widths();
        w_out_ready = 1'b0;
        w_in_valid = 1'b1;
        w_in_data1 = 64'hFFFF_0000_1234_5678;
        w_in_data2 = 64'h8000_0000_0000_0001;
        w_in_rd = 6'h2A;
        w_in_ctrl = 16'hBEEF;
        tick();
        w_in_valid = 1'b0;
        n_checks++; if (w_exec_data_1 !== 64'hFFFF_0000_1234_5678) begin n_fail++; $display("FAIL wide_data1 got=%h exp=ffff000012345678", w_exec_data_1); end
        n_checks++; if (w_exec_data_2 !== 64'h8000_0000_0000_0001 || w_exec_rd !== 6'h2A || w_exec_ctrl !== 16'hBEEF || w_occupancy !== 2'd1)
            begin n_fail++; $display("FAIL wide_fields got=%h/%h/%h/%0d exp=8000000000000001/2a/beef/1", w_exec_data_2, w_exec_rd, w_exec_ctrl, w_occupancy); end
        w_out_ready = 1'b1;
        tick();
        n_checks++; if (w_out_valid !== 1'b0 || w_exec_data_1 !== 64'h0) begin n_fail++; $display("FAIL wide_drain got=%b/%h exp=0/0", w_out_valid, w_exec_data_1); end
    endtask

    task automatic test_random();
        ent_t e;
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) >= 2);
            flush     = ($urandom_range(0, 99) < 5);
            out_ready = $urandom_range(0, 1);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom), 8'($urandom));
            tick();
            e = '{d1: '0, d2: '0, rd: '0, ctrl: '0};
            if (mq.size() > 0) e = mq[0];
            n_checks++;
            if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() > 0) ||
                exec_data_1 !== e.d1 || exec_data_2 !== e.d2 || exec_rd !== e.rd || exec_ctrl !== e.ctrl) begin
                n_fail++;
                $display("FAIL random_%0d got=%0d/%b/%h/%h/%h/%h exp=%0d/%b/%h/%h/%h/%h", i,
                         occupancy, out_valid, exec_data_1, exec_data_2, exec_rd, exec_ctrl,
                         mq.size(), mq.size() > 0, e.d1, e.d2, e.rd, e.ctrl);
            end
            n_checks++;
            if (in_ready !== (reset && mq.size() < 2)) begin
                n_fail++;
                $display("FAIL random_in_ready_%0d got=%b exp=%b", i, in_ready, reset && mq.size() < 2);
            end
        end
        flush = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_reset_mid();
        test_widths();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
